// File: rtl/stopwatch_display_decoder.sv
// Recovers a stopwatch time (MM:SS) by snooping a multiplexed, active-low
// 4-digit 7-segment display bus and debouncing each digit's dwell.
module stopwatch_display_decoder #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  seg_in,
  input  logic        dp_in,
  input  logic [3:0]  an_in,
  output logic [15:0] bcd_out,
  output logic [5:0]  sec_out,
  output logic [5:0]  min_out,
  output logic [3:0]  dp_out,
  output logic        frame_valid,
  output logic        seg_err
);

  localparam logic [4:0] CNT_CAP = 5'(STABLE_CNT);
  localparam logic [4:0] CNT_SAT = 5'(STABLE_CNT + 1);

  logic [3:0]       an_q;
  logic [6:0]       seg_q;
  logic             dp_q;
  logic [11:0]      prev_q;
  logic [4:0]       cnt_q, cnt_d;
  logic [3:0]       mask_q;
  logic [3:0][3:0]  stage_q;
  logic [3:0]       sdp_q;

  logic [3:0]       sel;
  logic             legal;
  logic             cap;
  logic             dig_ok;
  logic [3:0]       dig;
  logic [3:0]       mask_d;
  logic [3:0][3:0]  stage_d;
  logic [3:0]       sdp_d;
  logic             range_ok;
  logic [5:0]       sec_bin, min_bin;

  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7D:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h6F:   decode = {1'b1, 4'd9};
      default: decode = {1'b0, 4'd0};
    endcase
  endfunction

  function automatic logic [5:0] to_bin(input logic [3:0] tens, input logic [3:0] ones);
    to_bin = ({2'b00, tens} << 3) + ({2'b00, tens} << 1) + {2'b00, ones};
  endfunction

  // cnt_q is the number of identical samples seen for the sample held in prev_q
  always_comb begin
    cnt_d = 5'd1;
    if (&an_q)
      cnt_d = 5'd0;
    else if ({an_q, seg_q, dp_q} == prev_q)
      cnt_d = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 5'd1;
  end

  assign sel    = ~prev_q[11:8];
  assign legal  = (sel != 4'd0) && ((sel & (sel - 4'd1)) == 4'd0);
  assign cap    = (cnt_q == CNT_CAP);
  assign {dig_ok, dig} = decode(~prev_q[7:1]);
  assign mask_d = mask_q | sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_stage
    assign stage_d[gi] = sel[gi] ? dig : stage_q[gi];
    assign sdp_d[gi]   = sel[gi] ? ~prev_q[0] : sdp_q[gi];
  end

  assign range_ok = (stage_d[1] <= 4'd5) && (stage_d[3] <= 4'd5);
  assign sec_bin  = to_bin(stage_d[1], stage_d[0]);
  assign min_bin  = to_bin(stage_d[3], stage_d[2]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q        <= '0;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      prev_q      <= '0;
      cnt_q       <= '0;
      mask_q      <= '0;
      stage_q     <= '0;
      sdp_q       <= '0;
      bcd_out     <= '0;
      sec_out     <= '0;
      min_out     <= '0;
      dp_out      <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
    end else begin
      an_q        <= an_in;
      seg_q       <= seg_in;
      dp_q        <= dp_in;
      prev_q      <= {an_q, seg_q, dp_q};
      cnt_q       <= cnt_d;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      if (cap) begin
        if (!legal || !dig_ok) begin
          seg_err <= 1'b1;
          mask_q  <= '0;
          stage_q <= '0;
          sdp_q   <= '0;
        end else if (mask_d == 4'hF) begin
          mask_q <= '0;
          if (range_ok) begin
            bcd_out     <= stage_d;
            dp_out      <= sdp_d;
            sec_out     <= sec_bin;
            min_out     <= min_bin;
            frame_valid <= 1'b1;
          end else begin
            seg_err <= 1'b1;
          end
        end else begin
          mask_q  <= mask_d;
          stage_q <= stage_d;
          sdp_q   <= sdp_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_display_decoder.sv
// Directed, table-driven bench for stopwatch_display_decoder (STABLE_CNT=4).
module tb_stopwatch_display_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_in;
  logic        dp_in;
  logic [3:0]  an_in;
  logic [15:0] bcd_out;
  logic [5:0]  sec_out, min_out;
  logic [3:0]  dp_out;
  logic        frame_valid, seg_err;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  stopwatch_display_decoder #(.STABLE_CNT(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .an_in(an_in),
    .bcd_out(bcd_out), .sec_out(sec_out), .min_out(min_out), .dp_out(dp_out),
    .frame_valid(frame_valid), .seg_err(seg_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid) fv_cnt++;
    if (seg_err) err_cnt++;
    if (frame_valid && seg_err) both_cnt++;
  end

  typedef struct {
    logic [3:0][6:0] pat;    // active-high gfedcba, index = digit
    logic [3:0]      dp;     // active-high dp request per digit
    logic [3:0][3:0] dwell;  // cycles per digit, 0 = digit skipped
    int              exp_fv;
    int              exp_err;
    logic [15:0]     exp_bcd;
    logic [5:0]      exp_sec;
    logic [5:0]      exp_min;
    logic [3:0]      exp_dp;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] pat, input logic dp_on, input int n);
    an_in  = an;
    seg_in = ~pat;
    dp_in  = ~dp_on;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic blank(input int n);
    drive(4'hF, 7'h00, 1'b0, n);
  endtask

  task automatic scan_1234();
    drive(4'b1110, 7'h66, 1'b0, 8);
    drive(4'b1101, 7'h4F, 1'b0, 8);
    drive(4'b1011, 7'h5B, 1'b0, 8);
    drive(4'b0111, 7'h06, 1'b0, 8);
    blank(6);
  endtask

  task automatic check_outs(input string tag, input logic [15:0] bcd, input logic [5:0] s,
                            input logic [5:0] m, input logic [3:0] d);
    check({tag, " bcd_out"}, 32'(bcd_out), 32'(bcd));
    check({tag, " sec_out"}, 32'(sec_out), 32'(s));
    check({tag, " min_out"}, 32'(min_out), 32'(m));
    check({tag, " dp_out"},  32'(dp_out),  32'(d));
  endtask

  initial begin
    tbl[0] = '{{7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, {4'd8, 4'd8, 4'd8, 4'd8},
               1, 0, 16'h1234, 6'd34, 6'd12, 4'b0000};
    tbl[1] = '{{7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, {4'd3, 4'd8, 4'd8, 4'd8},
               0, 0, 16'h1234, 6'd34, 6'd12, 4'b0000};
    tbl[2] = '{{7'h06, 7'h5B, 7'h4F, 7'h66}, 4'b0000, {4'd4, 4'd0, 4'd0, 4'd0},
               1, 0, 16'h1234, 6'd34, 6'd12, 4'b0000};
    tbl[3] = '{{7'h06, 7'h00, 7'h4F, 7'h66}, 4'b0000, {4'd0, 4'd8, 4'd0, 4'd0},
               0, 1, 16'h1234, 6'd34, 6'd12, 4'b0000};
    tbl[4] = '{{7'h3F, 7'h6D, 7'h6D, 7'h6F}, 4'b0100, {4'd8, 4'd8, 4'd8, 4'd8},
               1, 0, 16'h0559, 6'd59, 6'd5, 4'b0100};
    tbl[5] = '{{7'h06, 7'h5B, 7'h7D, 7'h66}, 4'b0000, {4'd8, 4'd8, 4'd8, 4'd8},
               0, 1, 16'h0559, 6'd59, 6'd5, 4'b0100};

    // Reset with random inputs must clear outputs before any clock edge
    rst    = 1'b1;
    seg_in = 7'($urandom);
    dp_in  = 1'($urandom);
    an_in  = 4'($urandom);
    #1;
    check_outs("reset", 16'h0, 6'd0, 6'd0, 4'h0);
    check("reset frame_valid", 32'(frame_valid), 32'd0);
    check("reset seg_err", 32'(seg_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    an_in = 4'hF;
    rst   = 1'b0;
    blank(4);

    for (int i = 0; i < 6; i++) begin
      fv_cnt  = 0;
      err_cnt = 0;
      for (int d = 0; d < 4; d++) begin
        if (tbl[i].dwell[d] != 4'd0) begin
          logic [3:0] an_v;
          an_v    = 4'hF;
          an_v[d] = 1'b0;
          drive(an_v, tbl[i].pat[d], tbl[i].dp[d], int'(tbl[i].dwell[d]));
        end
      end
      blank(6);
      check($sformatf("row%0d frame_valid pulses", i), 32'(fv_cnt), 32'(tbl[i].exp_fv));
      check($sformatf("row%0d seg_err pulses", i), 32'(err_cnt), 32'(tbl[i].exp_err));
      check_outs($sformatf("row%0d", i), tbl[i].exp_bcd, tbl[i].exp_sec, tbl[i].exp_min, tbl[i].exp_dp);
      $display("row %0d: fv=%0d err=%0d bcd=%04h sec=%0d min=%0d dp=%b",
               i, fv_cnt, err_cnt, bcd_out, sec_out, min_out, dp_out);
    end

    // Illegal enable held long: exactly one error, outputs held
    fv_cnt  = 0;
    err_cnt = 0;
    drive(4'b1100, 7'h06, 1'b0, 20);
    blank(6);
    check("illegal an seg_err pulses", 32'(err_cnt), 32'd1);
    check("illegal an frame_valid pulses", 32'(fv_cnt), 32'd0);
    check_outs("illegal an", 16'h0559, 6'd59, 6'd5, 4'b0100);
    $display("illegal an: err=%0d fv=%0d bcd=%04h", err_cnt, fv_cnt, bcd_out);

    // Mid-frame reset: two digits captured, then async reset
    fv_cnt  = 0;
    err_cnt = 0;
    drive(4'b1110, 7'h66, 1'b0, 8);
    drive(4'b1101, 7'h4F, 1'b0, 8);
    #2;
    rst = 1'b1;
    #1;
    check_outs("async reset", 16'h0, 6'd0, 6'd0, 4'h0);
    an_in = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    blank(3);
    drive(4'b1011, 7'h5B, 1'b0, 8);
    drive(4'b0111, 7'h06, 1'b0, 8);
    blank(6);
    check("partial after reset frame_valid pulses", 32'(fv_cnt), 32'd0);
    check("partial after reset bcd_out", 32'(bcd_out), 32'h0);
    $display("mid-frame reset partial: fv=%0d bcd=%04h", fv_cnt, bcd_out);
    scan_1234();
    check("full after reset frame_valid pulses", 32'(fv_cnt), 32'd1);
    check_outs("full after reset", 16'h1234, 6'd34, 6'd12, 4'h0);
    $display("mid-frame reset full: fv=%0d bcd=%04h", fv_cnt, bcd_out);

    check("frame_valid with seg_err cycles", 32'(both_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
